avmm_core_master: RTL and testbench

- Avalon-MM master adapter directly upstream of the system's mm_bridge slave port.
- Converts the RISC-V core's load/store request/response interface into single-beat Avalon-MM read/write transactions.
- Handles byte lanes, waitrequest stalls, pipelined readdatavalid, and load sign/zero extension.
- One transaction outstanding at a time (burstcount fixed at 1).

---
 rtl/avmm_pkg.sv | 30 +++
 rtl/avmm_lane_align.sv | 48 ++++
 rtl/avmm_core_master.sv | 179 +++++++++++++++++
 tb/tb_avmm_core_master.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/avmm_pkg.sv
// Shared types and constants for the core-to-Avalon-MM master adapter.
package avmm_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        RDWAIT,
        RESP
    } state_e;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Request fields kept after acceptance; the core may change its inputs freely afterwards.
    typedef struct packed {
        logic       we;
        size_e      size;
        logic       uns;
        logic [1:0] lo;
    } req_t;

endpackage

// File: rtl/avmm_lane_align.sv
// Byte-lane steering: byteenable, store replication, load shift/extend, access legality.
// Latency: purely combinational.
// Backpressure: none; the owning FSM decides when the results are used.
module avmm_lane_align
    import avmm_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  size_e       size,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        acc_err
);

    logic [31:0] rdata_sh;

    always_comb begin
        rdata_sh  = rdata >> {addr_lo, 3'b000};
        be        = BE_WORD;
        wdata_rep = wdata;
        rdata_ext = rdata_sh;
        acc_err   = 1'b0;
        case (size)
            SZ_BYTE: begin
                be        = BE_BYTE << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{rdata_sh[7] & ~uns}}, rdata_sh[7:0]};
            end
            SZ_HALF: begin
                be        = BE_HALF << addr_lo;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{rdata_sh[15] & ~uns}}, rdata_sh[15:0]};
                acc_err   = addr_lo[0];
            end
            SZ_WORD: begin
                acc_err   = |addr_lo;
            end
            default: begin
                // Illegal size encoding is reported the same way as a misaligned access.
                acc_err   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/avmm_core_master.sv
// Core load/store to single-beat Avalon-MM master; optional watchdog under AVMM_TIMEOUT_EN.
// Latency: store rsp 2 cycles after accept, load 3 (plus waitrequest/readdatavalid delay).
// Backpressure: req_ready only in IDLE; one transaction outstanding; command held while waitrequest.
module avmm_core_master
    import avmm_pkg::*;
#(
    parameter int ADDR_W         = 28,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    output logic              avm_burstcount,
    output logic              avm_debugaccess,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_e            state_q, state_d;
    req_t              req_q, req_d;
    logic [ADDR_W-1:0] avm_address_q, avm_address_d;
    logic [3:0]        avm_byteenable_q, avm_byteenable_d;
    logic [31:0]       avm_writedata_q, avm_writedata_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic [1:0]  la_lo;
    size_e       la_size;
    logic        la_uns;
    logic [3:0]  la_be;
    logic [31:0] la_wdata;
    logic [31:0] la_rdata;
    logic        la_err;

`ifdef AVMM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

    // In IDLE the aligner looks at the live request; afterwards at the captured one.
    assign la_lo   = (state_q == IDLE) ? req_addr[1:0]      : req_q.lo;
    assign la_size = (state_q == IDLE) ? size_e'(req_size)  : req_q.size;
    assign la_uns  = (state_q == IDLE) ? req_unsigned       : req_q.uns;

    avmm_lane_align u_lane_align (
        .addr_lo   (la_lo),
        .size      (la_size),
        .uns       (la_uns),
        .wdata     (req_wdata),
        .rdata     (avm_readdata),
        .be        (la_be),
        .wdata_rep (la_wdata),
        .rdata_ext (la_rdata),
        .acc_err   (la_err)
    );

    always_comb begin
        state_d          = state_q;
        req_d            = req_q;
        avm_address_d    = avm_address_q;
        avm_byteenable_d = avm_byteenable_q;
        avm_writedata_d  = avm_writedata_q;
        rsp_rdata_d      = rsp_rdata_q;
        rsp_err_d        = rsp_err_q;
`ifdef AVMM_TIMEOUT_EN
        tmo_cnt_d        = tmo_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d.we    = req_we;
                    req_d.size  = size_e'(req_size);
                    req_d.uns   = req_unsigned;
                    req_d.lo    = req_addr[1:0];
                    rsp_rdata_d = '0;
                    rsp_err_d   = la_err;
                    if (la_err) begin
                        state_d = RESP;
                    end else begin
                        avm_address_d    = {req_addr[ADDR_W-1:2], 2'b00};
                        avm_byteenable_d = la_be;
                        avm_writedata_d  = la_wdata;
                        state_d          = CMD;
`ifdef AVMM_TIMEOUT_EN
                        tmo_cnt_d        = '0;
`endif
                    end
                end
            end
            CMD: begin
                if (!avm_waitrequest) begin
                    state_d = req_q.we ? RESP : RDWAIT;
                end
            end
            RDWAIT: begin
                if (avm_readdatavalid) begin
                    rsp_rdata_d = la_rdata;
                    state_d     = RESP;
                end
            end
            RESP: begin
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef AVMM_TIMEOUT_EN
        // A genuine completion in the expiry cycle wins over the watchdog.
        if (state_q == CMD || state_q == RDWAIT) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
            if (state_d == state_q && tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                state_d     = RESP;
                rsp_err_d   = 1'b1;
                rsp_rdata_d = '0;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            req_q            <= '0;
            avm_address_q    <= '0;
            avm_byteenable_q <= '0;
            avm_writedata_q  <= '0;
            rsp_rdata_q      <= '0;
            rsp_err_q        <= 1'b0;
`ifdef AVMM_TIMEOUT_EN
            tmo_cnt_q        <= '0;
`endif
        end else begin
            state_q          <= state_d;
            req_q            <= req_d;
            avm_address_q    <= avm_address_d;
            avm_byteenable_q <= avm_byteenable_d;
            avm_writedata_q  <= avm_writedata_d;
            rsp_rdata_q      <= rsp_rdata_d;
            rsp_err_q        <= rsp_err_d;
`ifdef AVMM_TIMEOUT_EN
            tmo_cnt_q        <= tmo_cnt_d;
`endif
        end
    end

    // Reset gates the strobes directly so an aborted command disappears in the reset cycle.
    assign req_ready       = (state_q == IDLE);
    assign rsp_valid       = (state_q == RESP) & ~reset;
    assign rsp_rdata       = rsp_rdata_q;
    assign rsp_err         = rsp_err_q;
    assign avm_read        = (state_q == CMD) & ~req_q.we & ~reset;
    assign avm_write       = (state_q == CMD) &  req_q.we & ~reset;
    assign avm_address     = avm_address_q;
    assign avm_byteenable  = avm_byteenable_q;
    assign avm_writedata   = avm_writedata_q;
    assign avm_burstcount  = 1'b1;
    assign avm_debugaccess = 1'b0;

endmodule

// File: tb/tb_avmm_core_master.sv
// Scoreboarded bench for avmm_core_master: responses checked against a queue filled at request time.
module tb_avmm_core_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [27:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [27:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_burstcount;
    logic        avm_debugaccess;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    int          n_vec = 0;
    int          n_err = 0;
    logic [32:0] sb_q[$];
    logic [32:0] sb_exp;

    always #5 clk = ~clk;

    avmm_core_master #(.ADDR_W(28), .TIMEOUT_CYCLES(8)) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_we            (req_we),
        .req_addr          (req_addr),
        .req_size          (req_size),
        .req_unsigned      (req_unsigned),
        .req_wdata         (req_wdata),
        .rsp_valid         (rsp_valid),
        .rsp_rdata         (rsp_rdata),
        .rsp_err           (rsp_err),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_byteenable    (avm_byteenable),
        .avm_burstcount    (avm_burstcount),
        .avm_debugaccess   (avm_debugaccess),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && rsp_valid) begin
            if (sb_q.size() == 0) begin
                check_val("spurious_rsp", 32'd1, 32'd0);
            end else begin
                sb_exp = sb_q.pop_front();
                check_val("rsp_rdata", rsp_rdata, sb_exp[31:0]);
                check_val("rsp_err", {31'd0, rsp_err}, {31'd0, sb_exp[32]});
            end
        end
    end

    // One request; the bench plays the slave (stall cycles, read latency) and checks the bus side.
    task automatic do_txn(input bit we, input logic [27:0] addr, input logic [1:0] size,
                          input bit uns, input logic [31:0] wd, input int stall, input int rdly,
                          input logic [31:0] rd, input logic [31:0] exp_rd, input bit exp_err,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd, input int tmo);
        bit legal;
        bit seen;
        int cmd_end;
        int lat;
        legal   = !exp_err || (tmo > 0);
        cmd_end = (tmo > 0) ? tmo : stall + 1;
        lat     = !legal ? 1 : (tmo > 0) ? tmo + 1 : we ? stall + 2 : stall + rdly + 2;
        @(negedge clk);
        check_val("req_ready", {31'd0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wd;
        sb_q.push_back({exp_err, exp_rd});
        seen = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            req_addr  = 28'hFFFFFFF;
            req_wdata = 32'hFFFF_FFFF;
            if (legal && k <= cmd_end) begin
                check_val("cmd_read", {31'd0, avm_read}, {31'd0, !we});
                check_val("cmd_write", {31'd0, avm_write}, {31'd0, we});
                check_val("cmd_addr", {4'd0, avm_address}, {4'd0, addr[27:2], 2'b00});
                check_val("cmd_be", {28'd0, avm_byteenable}, {28'd0, exp_be});
                if (we) check_val("cmd_wdata", avm_writedata, exp_wd);
                avm_waitrequest = (k <= stall);
            end else begin
                check_val("bus_idle", {30'd0, avm_read, avm_write}, 32'd0);
                avm_waitrequest = 1'b0;
            end
            avm_readdatavalid = legal && !we && (tmo == 0) && (k == stall + 1 + rdly);
            avm_readdata      = avm_readdatavalid ? rd : 32'h5A5A_5A5A;
            if (rsp_valid) begin
                seen = 1'b1;
                check_val("rsp_latency", k, lat);
            end
        end
        if (!seen) check_val("rsp_missing", 32'd0, 32'd1);
        @(negedge clk);
        avm_readdatavalid = 1'b0;
        avm_waitrequest   = 1'b0;
        check_val("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
        check_val("ready_back", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset             = 1'b1;
        req_valid         = 1'b0;
        req_we            = 1'b0;
        req_addr          = '0;
        req_size          = '0;
        req_unsigned      = 1'b0;
        req_wdata         = '0;
        avm_waitrequest   = 1'b0;
        avm_readdata      = '0;
        avm_readdatavalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_ready", {31'd0, req_ready}, 32'd1);
        check_val("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_val("rst_rsp_rdata", rsp_rdata, 32'd0);
        check_val("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check_val("rst_bus_strobes", {30'd0, avm_read, avm_write}, 32'd0);
        check_val("rst_address", {4'd0, avm_address}, 32'd0);
        check_val("rst_writedata", avm_writedata, 32'd0);
        check_val("rst_byteenable", {28'd0, avm_byteenable}, 32'd0);
        check_val("burstcount", {31'd0, avm_burstcount}, 32'd1);
        check_val("debugaccess", {31'd0, avm_debugaccess}, 32'd0);
        reset = 1'b0;

        //     we addr        sz     uns wdata         stl rdl readdata      exp_rdata     err be     exp_wdata    tmo
        do_txn(1, 28'h0000010, 2'b10, 0, 32'hDEADBEEF, 0, 0, 32'h0,        32'h0,        0, 4'hF, 32'hDEADBEEF, 0);
        do_txn(0, 28'h0000013, 2'b00, 0, 32'h0,        0, 1, 32'h80FF0000, 32'hFFFFFF80, 0, 4'h8, 32'h0,        0);
        do_txn(0, 28'h0000013, 2'b00, 1, 32'h0,        0, 1, 32'h80FF0000, 32'h00000080, 0, 4'h8, 32'h0,        0);
        do_txn(1, 28'h0000006, 2'b01, 0, 32'hABCD1234, 5, 0, 32'h0,        32'h0,        0, 4'hC, 32'h12341234, 0);
        do_txn(0, 28'h0000001, 2'b01, 0, 32'h0,        0, 1, 32'h0,        32'h0,        1, 4'h0, 32'h0,        0);
        do_txn(0, 28'h0000008, 2'b11, 0, 32'h0,        0, 1, 32'h0,        32'h0,        1, 4'h0, 32'h0,        0);
        do_txn(1, 28'h0000002, 2'b10, 0, 32'h11223344, 0, 0, 32'h0,        32'h0,        1, 4'h0, 32'h0,        0);
        do_txn(0, 28'h0000002, 2'b01, 0, 32'h0,        0, 1, 32'h80011234, 32'hFFFF8001, 0, 4'hC, 32'h0,        0);
        do_txn(0, 28'h0000002, 2'b01, 1, 32'h0,        0, 2, 32'h80011234, 32'h00008001, 0, 4'hC, 32'h0,        0);
        do_txn(0, 28'h0000024, 2'b10, 0, 32'h0,        2, 3, 32'hCAFEF00D, 32'hCAFEF00D, 0, 4'hF, 32'h0,        0);
        do_txn(1, 28'h0000005, 2'b00, 0, 32'h000000A5, 1, 0, 32'h0,        32'h0,        0, 4'h2, 32'hA5A5A5A5, 0);
        do_txn(0, 28'h0000001, 2'b00, 0, 32'h0,        0, 1, 32'h00007F00, 32'h0000007F, 0, 4'h2, 32'h0,        0);
        do_txn(0, 28'h0000000, 2'b00, 1, 32'h0,        0, 1, 32'h123456FE, 32'h000000FE, 0, 4'h1, 32'h0,        0);
        do_txn(0, 28'hABCDEF0, 2'b00, 0, 32'h0,        1, 1, 32'h123456FE, 32'hFFFFFFFE, 0, 4'h1, 32'h0,        0);

        // Reset while a read command is stalled: strobe must drop in the reset cycle.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 28'h0000040; req_size = 2'b10; req_unsigned = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        avm_waitrequest = 1'b1;
        check_val("rstcmd_read_up", {31'd0, avm_read}, 32'd1);
        reset = 1'b1;
        #1;
        check_val("rstcmd_read_drop", {31'd0, avm_read}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        avm_waitrequest = 1'b0;
        check_val("rstcmd_idle", {31'd0, req_ready}, 32'd1);

        // Reset in RDWAIT, then a late readdatavalid that must be ignored.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 28'h0000020; req_size = 2'b10;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check_val("rstrd_read_low", {31'd0, avm_read}, 32'd0);
        check_val("rstrd_busy", {31'd0, req_ready}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'hBAD0BAD0;
        check_val("rstrd_idle", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        avm_readdatavalid = 1'b0;
        check_val("rstrd_no_rsp", {31'd0, rsp_valid}, 32'd0);
        check_val("rstrd_still_idle", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        check_val("rstrd_no_rsp2", {31'd0, rsp_valid}, 32'd0);
        do_txn(0, 28'h0000030, 2'b10, 0, 32'h0, 0, 1, 32'h5555AAAA, 32'h5555AAAA, 0, 4'hF, 32'h0, 0);

`ifdef AVMM_TIMEOUT_EN
        do_txn(0, 28'h0000050, 2'b10, 0, 32'h0, 1000, 1, 32'h0, 32'h0, 1, 4'hF, 32'h0, 8);
        do_txn(1, 28'h0000054, 2'b10, 0, 32'h01020304, 0, 0, 32'h0, 32'h0, 0, 4'hF, 32'h01020304, 0);
`endif

        repeat (3) @(negedge clk);
        check_val("sb_drained", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
